// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
//
// Shared definitions for the 256x32 SRAM request path.
//
// Contents:
//   ADR_W, DAT_W, STRB_W  word-address, data and byte-strobe widths of the
//                         SRAM macro
//   rsp_entry_t           one queued response: write-ack flag and read data
//   merge_wstrb()         byte-lane merge of new write data over an old word.
//                         This is what the SRAM does on a strobed write, so
//                         reference models and checkers can predict the
//                         contents of memory after a partial write.
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int ADR_W  = 8;
    localparam int DAT_W  = 32;
    localparam int STRB_W = DAT_W / 8;

    // A response as it sits in the response FIFO. Write acks carry zero data,
    // so a consumer can ignore rdata whenever write is set.
    typedef struct packed {
        logic             write;
        logic [DAT_W-1:0] rdata;
    } rsp_entry_t;

    // Replace each byte lane of old_data whose strobe bit is set with the
    // corresponding lane of new_data; lanes with a clear strobe keep the old
    // byte. A zero strobe returns old_data unchanged.
    function automatic logic [DAT_W-1:0] merge_wstrb(
        input logic [DAT_W-1:0]  old_data,
        input logic [DAT_W-1:0]  new_data,
        input logic [STRB_W-1:0] strb
    );
        logic [DAT_W-1:0] result;
        result = old_data;
        for (int lane = 0; lane < STRB_W; lane++) begin
            if (strb[lane]) begin
                result[8*lane +: 8] = new_data[8*lane +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// sram_rsp_fifo
//
// Small synchronous FIFO that holds completed responses until the consumer
// takes them. First-word-fall-through: the oldest entry is always visible on
// head_data while the FIFO is not empty.
//
// Parameters:
//   WIDTH   bits per entry
//   DEPTH   number of entries (any value >= 1)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset; empties the FIFO
//   push       in   write push_data into the tail this cycle
//   push_data  in   entry to store
//   pop        in   drop the head entry this cycle
//   head_data  out  oldest stored entry (undefined content while empty)
//   empty      out  no entries stored
//   count      out  number of entries stored, 0..DEPTH
//
// The owner is expected never to push into a full FIFO nor pop an empty
// one; both are flagged by assertions rather than silently absorbed.
// ---------------------------------------------------------------------------
module sram_rsp_fifo #(
    parameter int  WIDTH = 33,
    parameter int  DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly at DEPTH-1 so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = storage[rd_ptr];

    // Entry storage carries no reset: an entry is only ever read after it
    // has been written, and emptiness is tracked by count alone.
    always_ff @(posedge clock) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
    // both pointers and leaves the count where it was.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A push into a full FIFO would lose a response; upstream credit
    // accounting must make this impossible.
    fifo_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && full));

    fifo_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(pop && empty));

endmodule

// File: rtl/sram_req_ctrl.sv
// ---------------------------------------------------------------------------
// sram_req_ctrl
//
// Request-side front end of the 256x32 SRAM. Turns a valid/ready request
// channel into the SRAM's pin-level interface and returns one in-order
// response per request (read data, or a zero-data ack for writes).
//
// Parameters:
//   RSP_DEPTH  response FIFO entries; also the total number of requests that
//              may be outstanding (queued responses plus the one in flight)
//   CNT_W      width of the completed-read / completed-write counters
//
// Ports:
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   io_req_valid  in   request present
//   io_req_ready  out  request accepted when valid && ready
//   io_req_write  in   1 = write, 0 = read
//   io_req_adr    in   word address
//   io_req_wdata  in   write data
//   io_req_wstrb  in   byte enables, bit i covers data bits [8i+7:8i]
//   io_rsp_valid  out  response available
//   io_rsp_ready  in   response consumed when valid && ready
//   io_rsp_write  out  response is a write ack
//   io_rsp_rdata  out  read data, 0 for write acks
//   io_cen        out  SRAM chip enable, active low
//   io_wen        out  SRAM write enable, active low
//   io_wstrb      out  SRAM byte strobes
//   io_adr        out  SRAM address
//   io_d          out  SRAM write data
//   io_q          in   SRAM read data, valid the cycle after a read issue
//   io_rd_cnt     out  completed reads, wrapping
//   io_wr_cnt     out  completed writes, wrapping
//
// Timing: a request accepted in cycle N drives the SRAM pins in cycle N.
// In cycle N+1 the access is "in flight": io_q holds the read word and the
// response is pushed at the end of that cycle, so the earliest response is
// visible in cycle N+2. Requests can be accepted every cycle as long as the
// consumer keeps up.
// ---------------------------------------------------------------------------
module sram_req_ctrl
    import sram_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_write,
    input  logic [ADR_W-1:0]  io_req_adr,
    input  logic [DAT_W-1:0]  io_req_wdata,
    input  logic [STRB_W-1:0] io_req_wstrb,

    output logic              io_rsp_valid,
    input  logic              io_rsp_ready,
    output logic              io_rsp_write,
    output logic [DAT_W-1:0]  io_rsp_rdata,

    output logic              io_cen,
    output logic              io_wen,
    output logic [STRB_W-1:0] io_wstrb,
    output logic [ADR_W-1:0]  io_adr,
    output logic [DAT_W-1:0]  io_d,
    input  logic [DAT_W-1:0]  io_q,

    output logic [CNT_W-1:0]  io_rd_cnt,
    output logic [CNT_W-1:0]  io_wr_cnt
);

    localparam int FIFO_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CREDIT_W   = FIFO_CNT_W + 1;

    logic                  fire;
    logic                  inflight;
    logic                  inflight_write;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_empty;
    logic [CREDIT_W-1:0]   credits_used;
    logic                  rsp_pop;
    rsp_entry_t            push_entry;
    rsp_entry_t            head_entry;

    // Credit check: every accepted request owns a FIFO slot from the moment
    // it is accepted, so an in-flight access counts as much as a queued
    // response. Only registered state feeds this, which keeps io_req_ready
    // free of any path from io_rsp_ready. Holding ready low during reset
    // also guarantees nothing is issued to the SRAM while reset is asserted.
    assign credits_used = CREDIT_W'(fifo_count) + CREDIT_W'(inflight);
    assign io_req_ready = reset_n && (credits_used < CREDIT_W'(RSP_DEPTH));
    assign fire         = io_req_valid && io_req_ready;

    // SRAM pin drive. The macro samples its pins on the next rising edge, so
    // the pins follow the accepted request combinationally. Idle cycles park
    // every pin at its inactive value with zeroed address and data, and a
    // read never presents write data or strobes.
    always_comb begin
        io_cen   = 1'b1;
        io_wen   = 1'b1;
        io_adr   = '0;
        io_d     = '0;
        io_wstrb = '0;
        if (fire) begin
            io_cen = 1'b0;
            io_wen = !io_req_write;
            io_adr = io_req_adr;
            if (io_req_write) begin
                io_d     = io_req_wdata;
                io_wstrb = io_req_wstrb;
            end
        end
    end

    // Remember that an access was issued last cycle and whether it was a
    // write. A reset drops any access in flight, so its response never
    // reaches the FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight       <= 1'b0;
            inflight_write <= 1'b0;
        end else begin
            inflight       <= fire;
            inflight_write <= fire && io_req_write;
        end
    end

    // The response for the in-flight access: io_q is valid exactly now for
    // a read, while a write ack carries zero data regardless of io_q.
    always_comb begin
        push_entry.write = inflight_write;
        push_entry.rdata = inflight_write ? '0 : io_q;
    end

    // Completion counters advance on the same edge that queues the response,
    // so a request counts as completed once its response exists. They wrap
    // silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_rd_cnt <= '0;
            io_wr_cnt <= '0;
        end else if (inflight) begin
            if (inflight_write) begin
                io_wr_cnt <= io_wr_cnt + CNT_W'(1);
            end else begin
                io_rd_cnt <= io_rd_cnt + CNT_W'(1);
            end
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DAT_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (rsp_pop),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Response channel. The head fields are masked with valid so that an
    // empty FIFO (including throughout reset) shows all-zero outputs rather
    // than whatever stale entry the storage still holds.
    assign io_rsp_valid = !fifo_empty;
    assign rsp_pop      = io_rsp_valid && io_rsp_ready;
    assign io_rsp_write = io_rsp_valid && head_entry.write;
    assign io_rsp_rdata = io_rsp_valid ? head_entry.rdata : '0;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_req_ctrl
//
// Self-checking bench for sram_req_ctrl. A behavioural 256x32 SRAM hangs off
// the pin interface. A separate reference memory, updated in request order
// as requests are accepted, predicts every response; a scoreboard queue
// holds the predictions until the DUT delivers them.
//
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_sram_req_ctrl;
    import sram_pkg::*;

    localparam int RSP_DEPTH = 4;
    localparam int CNT_W     = 16;

    logic              clock;
    logic              reset_n;
    logic              io_req_valid;
    logic              io_req_ready;
    logic              io_req_write;
    logic [ADR_W-1:0]  io_req_adr;
    logic [DAT_W-1:0]  io_req_wdata;
    logic [STRB_W-1:0] io_req_wstrb;
    logic              io_rsp_valid;
    logic              io_rsp_ready;
    logic              io_rsp_write;
    logic [DAT_W-1:0]  io_rsp_rdata;
    logic              io_cen;
    logic              io_wen;
    logic [STRB_W-1:0] io_wstrb;
    logic [ADR_W-1:0]  io_adr;
    logic [DAT_W-1:0]  io_d;
    logic [DAT_W-1:0]  io_q;
    logic [CNT_W-1:0]  io_rd_cnt;
    logic [CNT_W-1:0]  io_wr_cnt;

    int assertCount = 0;
    int errorCount  = 0;
    int rspSeen     = 0;

    rsp_entry_t       expQ[$];
    logic [CNT_W-1:0] expRdCnt;
    logic [CNT_W-1:0] expWrCnt;

    sram_req_ctrl #(
        .RSP_DEPTH (RSP_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_write (io_req_write),
        .io_req_adr   (io_req_adr),
        .io_req_wdata (io_req_wdata),
        .io_req_wstrb (io_req_wstrb),
        .io_rsp_valid (io_rsp_valid),
        .io_rsp_ready (io_rsp_ready),
        .io_rsp_write (io_rsp_write),
        .io_rsp_rdata (io_rsp_rdata),
        .io_cen       (io_cen),
        .io_wen       (io_wen),
        .io_wstrb     (io_wstrb),
        .io_adr       (io_adr),
        .io_d         (io_d),
        .io_q         (io_q),
        .io_rd_cnt    (io_rd_cnt),
        .io_wr_cnt    (io_wr_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Initial word content: low byte is the address, with two words chosen
    // for the directed read and partial-write cases.
    function automatic logic [DAT_W-1:0] initWord(input int a);
        if (a == 5)  return 32'hA1B2C305;
        if (a == 16) return 32'hDEADBE10;
        return 32'h5A5A0000 | 32'(a);
    endfunction

    // Behavioural SRAM: write or read on the rising edge, read data held on
    // io_q until the next read.
    logic [DAT_W-1:0] sramMem [256];
    logic [DAT_W-1:0] sramQ;
    assign io_q = sramQ;

    initial begin
        for (int a = 0; a < 256; a++) sramMem[a] = initWord(a);
        sramQ = '0;
        forever begin
            @(posedge clock);
            if (!io_cen) begin
                if (!io_wen) sramMem[io_adr] <= merge_wstrb(sramMem[io_adr], io_d, io_wstrb);
                else         sramQ <= sramMem[io_adr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard: responses are compared when consumed; accepted requests
    // are predicted from the reference memory in acceptance order.
    logic [DAT_W-1:0] refMem [256];
    initial begin
        rsp_entry_t e;
        for (int a = 0; a < 256; a++) refMem[a] = initWord(a);
        forever begin
            @(negedge clock);
            if (reset_n && io_rsp_valid && io_rsp_ready) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    errorCount++;
                    $display("[TB] FAIL rsp_unexpected: actual response rdata=0x%08h required none pending", io_rsp_rdata);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_write", 32'(io_rsp_write), 32'(e.write));
                    checkOutput("rsp_rdata", io_rsp_rdata, e.rdata);
                    rspSeen++;
                end
            end
            if (reset_n && io_req_valid && io_req_ready) begin
                e.write = io_req_write;
                if (io_req_write) begin
                    e.rdata = '0;
                    refMem[io_req_adr] = merge_wstrb(refMem[io_req_adr], io_req_wdata, io_req_wstrb);
                    expWrCnt++;
                end else begin
                    e.rdata = refMem[io_req_adr];
                    expRdCnt++;
                end
                expQ.push_back(e);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic              valid;
        logic              write;
        logic [ADR_W-1:0]  adr;
        logic [DAT_W-1:0]  wdata;
        logic [STRB_W-1:0] wstrb;
        logic              expReady;
        logic              expCen;
        logic              expWen;
        logic [ADR_W-1:0]  expAdr;
        logic [DAT_W-1:0]  expD;
        logic [STRB_W-1:0] expStrb;
    } vec_t;

    vec_t vecs[8];

    // One table vector occupies one cycle: drive, check pins mid-cycle,
    // let the edge accept it.
    task automatic applyStimulus(input vec_t v, input int idx);
        io_req_valid = v.valid;
        io_req_write = v.write;
        io_req_adr   = v.adr;
        io_req_wdata = v.wdata;
        io_req_wstrb = v.wstrb;
        @(negedge clock);
        checkOutput($sformatf("vec%0d_ready", idx), 32'(io_req_ready), 32'(v.expReady));
        checkOutput($sformatf("vec%0d_cen", idx),   32'(io_cen),       32'(v.expCen));
        checkOutput($sformatf("vec%0d_wen", idx),   32'(io_wen),       32'(v.expWen));
        checkOutput($sformatf("vec%0d_adr", idx),   32'(io_adr),       32'(v.expAdr));
        checkOutput($sformatf("vec%0d_d", idx),     io_d,              v.expD);
        checkOutput($sformatf("vec%0d_wstrb", idx), 32'(io_wstrb),     32'(v.expStrb));
        @(posedge clock); #1;
    endtask

    task automatic sendReq(input logic wr, input logic [7:0] adr, input logic [31:0] wd,
                           input logic [3:0] st, output int stalls);
        stalls       = 0;
        io_req_valid = 1'b1;
        io_req_write = wr;
        io_req_adr   = adr;
        io_req_wdata = wd;
        io_req_wstrb = st;
        @(negedge clock);
        while (!io_req_ready && stalls < 50) begin
            @(negedge clock);
            stalls++;
        end
        if (!io_req_ready) begin
            assertCount++;
            errorCount++;
            $display("[TB] FAIL req_timeout: actual ready=0 after %0d cycles required ready=1", stalls);
        end
        @(posedge clock); #1;
        io_req_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        io_rsp_ready = 1'b1;
        while ((expQ.size() != 0 || io_rsp_valid) && n < 200) begin
            @(negedge clock);
            n++;
        end
        assertCount++;
        if (expQ.size() != 0 || io_rsp_valid) begin
            errorCount++;
            $display("[TB] FAIL %s: actual %0d responses outstanding required 0", name, expQ.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic doReset();
        reset_n      = 1'b0;
        io_req_valid = 1'b0;
        io_rsp_ready = 1'b0;
        expQ.delete();
        expRdCnt = '0;
        expWrCnt = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int stalls;
        int totalStalls;
        int accepted;
        int staleCount;
        int rspBase;
        logic wr;
        logic [7:0] adr;

        vecs[0] = '{1'b0, 1'b1, 8'h33, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 8'h21, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b1, 8'h21, 32'h0, 4'h0};
        vecs[2] = '{1'b1, 1'b1, 8'h22, 32'h01020304, 4'hF, 1'b1, 1'b0, 1'b0, 8'h22, 32'h01020304, 4'hF};
        vecs[3] = '{1'b1, 1'b1, 8'h23, 32'h55667788, 4'h0, 1'b1, 1'b0, 1'b0, 8'h23, 32'h55667788, 4'h0};
        vecs[4] = '{1'b1, 1'b1, 8'h24, 32'h9ABCDEF0, 4'hA, 1'b1, 1'b0, 1'b0, 8'h24, 32'h9ABCDEF0, 4'hA};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 32'h12345678, 4'h5, 1'b1, 1'b0, 1'b1, 8'hFF, 32'h0, 4'h0};
        vecs[6] = '{1'b1, 1'b0, 8'h23, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 8'h23, 32'h0, 4'h0};
        vecs[7] = '{1'b0, 1'b0, 8'h80, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 4'h0};

        // Reset state, with a request offered to show it is ignored.
        reset_n      = 1'b0;
        io_req_valid = 1'b1;
        io_req_write = 1'b1;
        io_req_adr   = 8'h44;
        io_req_wdata = 32'hFFFFFFFF;
        io_req_wstrb = 4'hF;
        io_rsp_ready = 1'b1;
        expRdCnt     = '0;
        expWrCnt     = '0;
        @(negedge clock);
        checkOutput("rst_req_ready", 32'(io_req_ready), 32'h0);
        checkOutput("rst_cen",       32'(io_cen),       32'h1);
        checkOutput("rst_wen",       32'(io_wen),       32'h1);
        checkOutput("rst_adr",       32'(io_adr),       32'h0);
        checkOutput("rst_d",         io_d,              32'h0);
        checkOutput("rst_wstrb",     32'(io_wstrb),     32'h0);
        checkOutput("rst_rsp_valid", 32'(io_rsp_valid), 32'h0);
        checkOutput("rst_rsp_rdata", io_rsp_rdata,      32'h0);
        checkOutput("rst_rd_cnt",    32'(io_rd_cnt),    32'h0);
        doReset();

        // Single read of 0x05 with the response held back to observe latency.
        $display("[TB] single read");
        io_req_valid = 1'b1;
        io_req_write = 1'b0;
        io_req_adr   = 8'h05;
        io_req_wdata = 32'h0;
        io_req_wstrb = 4'h0;
        @(negedge clock);
        checkOutput("rd_ready", 32'(io_req_ready), 32'h1);
        checkOutput("rd_cen",   32'(io_cen),       32'h0);
        checkOutput("rd_wen",   32'(io_wen),       32'h1);
        checkOutput("rd_adr",   32'(io_adr),       32'h05);
        @(posedge clock); #1;
        io_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("rd_valid_n1", 32'(io_rsp_valid), 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("rd_valid_n2", 32'(io_rsp_valid), 32'h1);
        checkOutput("rd_rdata",    io_rsp_rdata,      32'hA1B2C305);
        checkOutput("rd_write",    32'(io_rsp_write), 32'h0);
        checkOutput("rd_cnt_1",    32'(io_rd_cnt),    32'h1);
        checkOutput("wr_cnt_0",    32'(io_wr_cnt),    32'h0);
        @(posedge clock); #1;
        waitDrain("drain_single");

        // Pin mapping vectors.
        $display("[TB] pin vectors");
        foreach (vecs[i]) applyStimulus(vecs[i], i);
        io_req_valid = 1'b0;
        waitDrain("drain_vectors");

        // Partial write then read of the same word in the next cycle.
        $display("[TB] write then read merge");
        io_rsp_ready = 1'b0;
        sendReq(1'b1, 8'h10, 32'h11223344, 4'b0101, stalls);
        sendReq(1'b0, 8'h10, 32'h0, 4'h0, stalls);
        @(negedge clock);
        checkOutput("merge_ack_valid", 32'(io_rsp_valid), 32'h1);
        checkOutput("merge_ack_write", 32'(io_rsp_write), 32'h1);
        checkOutput("merge_ack_rdata", io_rsp_rdata,      32'h0);
        @(posedge clock); #1;
        io_rsp_ready = 1'b1;
        @(posedge clock); #1;
        io_rsp_ready = 1'b0;
        @(negedge clock);
        checkOutput("merge_rd_write", 32'(io_rsp_write), 32'h0);
        checkOutput("merge_rd_rdata", io_rsp_rdata,      32'hDE22BE44);
        @(posedge clock); #1;
        waitDrain("drain_merge");

        // Credit limit with a stalled consumer.
        $display("[TB] credit stall");
        io_rsp_ready = 1'b0;
        accepted     = 0;
        io_req_valid = 1'b1;
        io_req_write = 1'b0;
        io_req_adr   = 8'h40;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (io_req_ready) accepted++;
            @(posedge clock); #1;
            io_req_adr = 8'h40 + 8'(accepted);
        end
        checkOutput("stall_accepts", 32'(accepted), 32'd4);
        @(negedge clock);
        checkOutput("stall_ready_low", 32'(io_req_ready), 32'h0);
        @(posedge clock); #1;
        io_rsp_ready = 1'b1;
        for (int c = 0; c < 40 && accepted < 6; c++) begin
            @(negedge clock);
            if (io_req_ready) accepted++;
            @(posedge clock); #1;
            io_req_adr = 8'h40 + 8'(accepted);
            if (accepted == 6) io_req_valid = 1'b0;
        end
        io_req_valid = 1'b0;
        checkOutput("stall_total_accepts", 32'(accepted), 32'd6);
        waitDrain("drain_stall");

        // 100 back-to-back mixed requests.
        $display("[TB] back-to-back mix");
        doReset();
        io_rsp_ready = 1'b1;
        rspBase      = rspSeen;
        totalStalls  = 0;
        for (int i = 0; i < 100; i++) begin
            wr  = ((i % 3) == 1);
            adr = ((i % 3) == 2) ? 8'((i - 1) * 37) : 8'(i * 37);
            sendReq(wr, adr, (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5, 4'(i), stalls);
            totalStalls += stalls;
        end
        checkOutput("b2b_stalls", 32'(totalStalls), 32'd0);
        waitDrain("drain_b2b");
        checkOutput("b2b_rsp_count", 32'(rspSeen - rspBase), 32'd100);
        checkOutput("b2b_cnt_sum",   32'(io_rd_cnt) + 32'(io_wr_cnt), 32'd100);
        checkOutput("b2b_rd_cnt",    32'(io_rd_cnt), 32'(expRdCnt));
        checkOutput("b2b_wr_cnt",    32'(io_wr_cnt), 32'(expWrCnt));

        // Reset with two responses queued and a read in flight.
        $display("[TB] reset mid-transfer");
        io_rsp_ready = 1'b0;
        sendReq(1'b0, 8'h05, 32'h0, 4'h0, stalls);
        sendReq(1'b0, 8'h06, 32'h0, 4'h0, stalls);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("pre_rst_valid", 32'(io_rsp_valid), 32'h1);
        @(posedge clock); #1;
        sendReq(1'b0, 8'h07, 32'h0, 4'h0, stalls);
        io_req_valid = 1'b1;
        io_req_adr   = 8'h09;
        reset_n      = 1'b0;
        expQ.delete();
        expRdCnt = '0;
        expWrCnt = '0;
        #1;
        checkOutput("mid_rst_rsp_valid", 32'(io_rsp_valid), 32'h0);
        checkOutput("mid_rst_rsp_rdata", io_rsp_rdata,      32'h0);
        checkOutput("mid_rst_cen",       32'(io_cen),       32'h1);
        checkOutput("mid_rst_ready",     32'(io_req_ready), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        io_req_valid = 1'b0;
        reset_n      = 1'b1;
        io_rsp_ready = 1'b1;
        staleCount   = 0;
        repeat (5) begin
            @(negedge clock);
            if (io_rsp_valid) staleCount++;
        end
        checkOutput("post_rst_stale", 32'(staleCount), 32'd0);
        checkOutput("post_rst_rd_cnt", 32'(io_rd_cnt), 32'h0);
        checkOutput("post_rst_wr_cnt", 32'(io_wr_cnt), 32'h0);
        @(posedge clock); #1;

        // Write counter wrap.
        $display("[TB] write counter wrap");
        io_rsp_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            sendReq(1'b1, 8'(i), 32'(i), 4'hF, stalls);
        end
        waitDrain("drain_wrap_pre");
        checkOutput("wr_cnt_ffff", 32'(io_wr_cnt), 32'h0000FFFF);
        sendReq(1'b1, 8'h00, 32'h0, 4'hF, stalls);
        waitDrain("drain_wrap");
        checkOutput("wr_cnt_wrap", 32'(io_wr_cnt), 32'h00000000);
        checkOutput("rd_cnt_wrap", 32'(io_rd_cnt), 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errorCount);
        $finish;
    end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request-side front end of the 256x32 SRAM model. Converts a valid/ready request channel into the SRAM's active-low io_cen/io_wen/io_wstrb/io_adr/io_d pins.
- Captures io_q one cycle after each read and returns in-order responses through a credit-limited response FIFO. One response is produced per request, including an ack for each write.
- Sits directly upstream of the SRAM macro. It is the stimulus path whose pin activity the memory checker monitors.

Parameters:
- ADR_W, 8: SRAM word-address width (256 words).
- DAT_W, 32: data width.
- STRB_W, 4: byte-strobe width, DAT_W/8.
- RSP_DEPTH, 4: response FIFO entries. Also the total credit limit (FIFO occupancy + in-flight).
- CNT_W, 16: width of the completed-request counters.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_req_valid  in  1  request present
- io_req_ready  out  1  request accepted this cycle when valid && ready
- io_req_write  in  1  1 = write, 0 = read
- io_req_adr  in  ADR_W  word address
- io_req_wdata  in  DAT_W  write data
- io_req_wstrb  in  STRB_W  byte enables; bit i covers bits [8i+7:8i]
- io_rsp_valid  out  1  response available
- io_rsp_ready  in  1  response consumed when valid && ready
- io_rsp_write  out  1  response is a write ack
- io_rsp_rdata  out  DAT_W  read data; 0 for write acks
- io_cen  out  1  SRAM chip enable, active low
- io_wen  out  1  SRAM write enable, active low
- io_wstrb  out  STRB_W  SRAM byte strobes
- io_adr  out  ADR_W  SRAM address
- io_d  out  DAT_W  SRAM write data
- io_q  in  DAT_W  SRAM read data, valid in the cycle after a read issue
- io_rd_cnt  out  CNT_W  completed reads, wraps at 2^CNT_W
- io_wr_cnt  out  CNT_W  completed writes, wraps at 2^CNT_W

Behaviour:
- Reset (async, reset_n low): FIFO empty, inflight=0, counters=0. While reset_n is low, force io_req_ready=0, io_cen=1, io_wen=1, io_wstrb=0, io_adr=0, io_d=0, io_rsp_valid=0, io_rsp_rdata=0, io_rsp_write=0. A reset mid-transfer discards any in-flight read and all queued responses.
- Credits: io_req_ready = (fifo_cnt + inflight) < RSP_DEPTH. It depends only on registered state, never on io_rsp_ready.
- Issue (cycle N, fire = io_req_valid && io_req_ready): the SRAM pins are driven combinationally in the same cycle.
  - io_cen=0.
  - io_wen = !io_req_write.
  - io_adr = io_req_adr.
  - io_d = write ? wdata : 0.
  - io_wstrb = write ? wstrb : 0.
  - When there is no fire: io_cen=1, io_wen=1, io_adr=0, io_d=0, io_wstrb=0.
- A write with wstrb=0 is still issued to the SRAM and still acknowledged.
- Capture: register inflight<=fire and inflight_write<=io_req_write at the end of cycle N. In cycle N+1, when inflight=1, push {write, write ? 0 : io_q} into the FIFO. The same edge increments io_wr_cnt or io_rd_cnt.
- Response: io_rsp_valid = FIFO not empty, with head data on io_rsp_write/io_rsp_rdata. Pop on valid && ready.
  - Latency from accept to earliest io_rsp_valid is 2 cycles.
  - A push and a pop in the same cycle leave the count unchanged.
  - Credits guarantee a push never hits a full FIFO. An overflow is an assertion failure.
- Throughput: back-to-back requests are sustained at 1 per cycle when io_rsp_ready=1. With io_rsp_ready=0, at most RSP_DEPTH requests are accepted, then io_req_ready=0.
- Ordering: responses return strictly in request order. A read after a write to the same address in the next cycle returns the merged data, because the SRAM performs the write first.
- Counter wrap: 0xFFFF+1 -> 0x0000, with no flag.

Decomposition:
- Package sram_pkg holds: ADR_W, DAT_W, STRB_W constants; the rsp_entry_t struct {write, rdata}; the function merge_wstrb(old, new, strb) for bench and checker reuse.
- One sub-module, sram_rsp_fifo: a parameterised synchronous FIFO with depth RSP_DEPTH, a count output, and async active-low reset.
- The issue/capture logic and counters stay in the top module.

Test Plan:
- Reset then single read at adr 0x05 (memory word 0xA1B2C305) -> io_cen=0/io_wen=1 in the accept cycle; io_rsp_valid 2 cycles later with rdata=0xA1B2C305, write=0; io_rd_cnt=1.
- Write adr 0x10, wdata 0x11223344, wstrb 0b0101 over old 0xDEADBE10, then read 0x10 the next cycle -> write ack (rdata=0); read returns 0xDE22BE44.
- io_rsp_ready=0 with 6 back-to-back reads offered -> exactly 4 accepted; io_req_ready=0 afterwards. Releasing ready drains 4 in-order responses, then the remaining 2 are accepted.
- 100 back-to-back mixed requests with io_rsp_ready=1 -> io_req_ready stays 1 throughout; 100 responses in order; io_rd_cnt + io_wr_cnt = 100.
- Assert reset_n low one cycle after a read issue with 2 responses queued -> io_rsp_valid=0 and io_cen=1 immediately; after release no stale response appears and the counters read 0.
- Preload io_wr_cnt to 0xFFFF via 65535 writes, then one more write -> io_wr_cnt=0x0000.
